memory_tdp_init: RTL and testbench

- Single-clock, true dual-port RAM with a byte-enable on every write.
- Read latency is configurable, and a valid strobe tracks each read through the output pipeline.
- Read-during-write behaviour is selectable.
- A post-reset clear sweep drives every location to a known value.
- Same-address write collisions resolve deterministically.
- Replaces the fixed-latency memory in datapath buffers that need a known initial state and partial-word writes.

---
 rtl/memory_pkg.sv | 11 +
 rtl/memory_rd_pipe.sv | 36 +++
 rtl/memory_tdp_init.sv | 119 +++++++++++
 tb/tb_memory_tdp_init.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared types and constants for the initialised true dual-port RAM.
package memory_pkg;

    typedef enum logic {READ_FIRST, WRITE_FIRST} rd_mode_e;

    typedef enum logic {ST_CLEAR, ST_READY} init_state_e;

    localparam int PA = 0;
    localparam int PB = 1;

endpackage

// File: rtl/memory_rd_pipe.sv
// Read-data delay line: data and valid travel RD_LAT stages together.
// A stage only loads data when valid, so the last stage holds the last result.
module memory_rd_pipe #(
    parameter int WIDTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_vld,
    input  logic [WIDTH-1:0] rd_data,
    output logic             vld,
    output logic [WIDTH-1:0] data
);

    logic [RD_LAT-1:0] vld_q;
    logic [WIDTH-1:0]  data_q [RD_LAT];

    // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) data_q[i] <= '0;
        end else begin
            vld_q[0] <= rd_vld;
            if (rd_vld) data_q[0] <= rd_data;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    assign vld  = vld_q[RD_LAT-1];
    assign data = data_q[RD_LAT-1];

endmodule

// File: rtl/memory_tdp_init.sv
// True dual-port RAM with byte enables, post-reset clear sweep,
// selectable read-during-write and deterministic write collisions.
module memory_tdp_init
    import memory_pkg::*;
#(
    parameter int             DEPTH        = 128,
    parameter int             WIDTH        = 32,
    parameter int             BYTE_W       = 8,
    parameter int             RD_LAT       = 1,
    parameter rd_mode_e       RD_MODE      = READ_FIRST,
    parameter bit             CLEAR_ON_RST = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VAL   = '0,
    localparam int            AWIDTH       = $clog2(DEPTH),
    localparam int            NBYTES       = WIDTH / BYTE_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   en,
    input  logic [1:0]                   we,
    input  logic [1:0][NBYTES-1:0]       be,
    input  logic [1:0][AWIDTH-1:0]       addr,
    input  logic [1:0][WIDTH-1:0]        din,
    output logic [1:0][WIDTH-1:0]        dout,
    output logic [1:0]                   dout_vld,
    output logic                         init_busy,
    output logic                         coll
);

    if (WIDTH % BYTE_W != 0) begin : g_chk_width
        $error("memory_tdp_init: WIDTH must be a multiple of BYTE_W");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_chk_lat
        $error("memory_tdp_init: RD_LAT must be in 1..4");
    end
    if (DEPTH < 2) begin : g_chk_depth
        $error("memory_tdp_init: DEPTH must be at least 2");
    end

    init_state_e          state, state_nxt;
    logic [AWIDTH-1:0]    cnt;
    logic [WIDTH-1:0]     mem [DEPTH];
    logic                 ready;
    logic [1:0]           in_range, wr_act, rd_act;
    logic [1:0][WIDTH-1:0] rd_word;

    assign ready     = (state == ST_READY);
    assign init_busy = (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR_ON_RST ? ST_CLEAR : ST_READY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) cnt <= cnt + AWIDTH'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && cnt == AWIDTH'(DEPTH - 1)) state_nxt = ST_READY;
    end

    // Cross-port reads always see the old word; only the own port's write can be merged in.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        in_range = '0;
        wr_act   = '0;
        rd_act   = '0;
        rd_word  = '0;
        for (int p = 0; p < 2; p++) begin
            in_range[p] = {1'b0, addr[p]} < (AWIDTH + 1)'(DEPTH);
            wr_act[p]   = ready && en[p] && we[p] && in_range[p];
            rd_act[p]   = ready && en[p];
            if (in_range[p]) begin
                rd_word[p] = mem[addr[p]];
                if (RD_MODE == WRITE_FIRST && wr_act[p]) begin
                    for (int b = 0; b < NBYTES; b++)
                        if (be[p][b]) rd_word[p][b*BYTE_W +: BYTE_W] = din[p][b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Port B is applied after port A, so B wins every lane both ports enable.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset branch; the clear sweep gives it a known state.
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[cnt] <= INIT_VAL;
            end else begin
                for (int p = 0; p < 2; p++)
                    for (int b = 0; b < NBYTES; b++)
                        if (wr_act[p] && be[p][b])
                            mem[addr[p]][b*BYTE_W +: BYTE_W] <= din[p][b*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) coll <= 1'b0;
        else     coll <= ready && (&en) && (&we) && (addr[PA] == addr[PB]);
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        memory_rd_pipe #(
            .WIDTH  (WIDTH),
            .RD_LAT (RD_LAT)
        ) u_rd_pipe (
            .clk     (clk),
            .rst     (rst),
            .rd_vld  (rd_act[p]),
            .rd_data (rd_word[p]),
            .vld     (dout_vld[p]),
            .data    (dout[p])
        );
    end

endmodule

// File: tb/tb_memory_tdp_init.sv
// Self-checking bench: one READ_FIRST and one WRITE_FIRST instance share stimulus
// and are compared every cycle against a word-array reference model.
module tb_memory_tdp_init;
    import memory_pkg::*;

    localparam int          DEPTH = 16;
    localparam int          LAT   = 2;
    localparam logic [31:0] INIT  = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       en, we;
    logic [1:0][3:0]  be, addr;
    logic [1:0][31:0] din;

    logic [1:0][31:0] dout_rf, dout_wf;
    logic [1:0]       vld_rf, vld_wf;
    logic             busy_rf, busy_wf, coll_rf, coll_wf;

    memory_tdp_init #(.DEPTH(DEPTH), .WIDTH(32), .BYTE_W(8), .RD_LAT(LAT),
                      .RD_MODE(READ_FIRST), .CLEAR_ON_RST(1'b1), .INIT_VAL(INIT))
    dut_rf (.clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din),
            .dout(dout_rf), .dout_vld(vld_rf), .init_busy(busy_rf), .coll(coll_rf));

    memory_tdp_init #(.DEPTH(DEPTH), .WIDTH(32), .BYTE_W(8), .RD_LAT(LAT),
                      .RD_MODE(WRITE_FIRST), .CLEAR_ON_RST(1'b1), .INIT_VAL(INIT))
    dut_wf (.clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din),
            .dout(dout_wf), .dout_vld(vld_wf), .init_busy(busy_wf), .coll(coll_wf));

    typedef struct {
        bit          v;
        logic [31:0] d;
    } ent_t;

    logic [31:0] mdl [DEPTH];
    bit          busy;
    int          cnt;
    bit          exp_coll;
    ent_t        rd_q [2][2][$];
    logic [31:0] hold [2][2];
    bit          exp_vld [2][2];
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] lanes);
        for (int b = 0; b < 4; b++) if (lanes[b]) old[b*8 +: 8] = nw[b*8 +: 8];
        return old;
    endfunction

    task automatic idle();
        en = '0; we = '0; be = '0; addr = '0; din = '0;
    endtask

    // One clock: update the model from the inputs seen at the edge, then check at the negedge.
    task automatic step();
        logic [31:0] old [DEPTH];
        ent_t        e;
        @(posedge clk);
        if (rst) begin
            busy = 1'b1; cnt = 0; exp_coll = 1'b0;
            for (int m = 0; m < 2; m++)
                for (int p = 0; p < 2; p++) begin
                    rd_q[m][p].delete();
                    for (int i = 0; i < LAT - 1; i++) rd_q[m][p].push_back('{v: 1'b0, d: 32'h0});
                    hold[m][p] = 32'h0;
                    exp_vld[m][p] = 1'b0;
                end
        end else begin
            exp_coll = !busy && en == 2'b11 && we == 2'b11 && addr[0] == addr[1];
            old = mdl;
            for (int m = 0; m < 2; m++)
                for (int p = 0; p < 2; p++) begin
                    e.v = !busy && en[p];
                    e.d = old[addr[p]];
                    if (m == 1 && we[p]) e.d = merge(e.d, din[p], be[p]);
                    rd_q[m][p].push_back(e);
                    e = rd_q[m][p].pop_front();
                    exp_vld[m][p] = e.v;
                    if (e.v) hold[m][p] = e.d;
                end
            if (busy) begin
                mdl[cnt] = INIT;
                cnt++;
                if (cnt == DEPTH) busy = 1'b0;
            end else begin
                for (int p = 0; p < 2; p++)
                    if (en[p] && we[p]) mdl[addr[p]] = merge(mdl[addr[p]], din[p], be[p]);
            end
        end
        @(negedge clk);
        chk("busy_rf", {31'b0, busy_rf}, {31'b0, busy});
        chk("busy_wf", {31'b0, busy_wf}, {31'b0, busy});
        chk("coll_rf", {31'b0, coll_rf}, {31'b0, exp_coll});
        chk("coll_wf", {31'b0, coll_wf}, {31'b0, exp_coll});
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("vld_rf_p%0d", p), {31'b0, vld_rf[p]}, {31'b0, exp_vld[0][p]});
            chk($sformatf("vld_wf_p%0d", p), {31'b0, vld_wf[p]}, {31'b0, exp_vld[1][p]});
            chk($sformatf("dout_rf_p%0d", p), dout_rf[p], hold[0][p]);
            chk($sformatf("dout_wf_p%0d", p), dout_wf[p], hold[1][p]);
        end
    endtask

    task automatic flush();
        idle();
        repeat (LAT) step();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst = 1'b1;
        idle();
        repeat (3) step();
        rst = 1'b0;

        // Interrupt the sweep after 7 cycles; a write during the restarted sweep is lost.
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        en[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 4'd3; din[0] = 32'h1234_5678;
        step();
        idle();
        guard = 0;
        while (busy && guard < 40) begin
            step();
            guard++;
        end

        for (int a = 0; a < DEPTH; a++) begin
            en[0] = 1'b1; addr[0] = 4'(a);
            step();
        end
        flush();
        chk("clear_last", dout_rf[0], INIT);

        // Byte-lane merge.
        en[0] = 1'b1; we[0] = 1'b1; be[0] = 4'b0101; addr[0] = 4'd5; din[0] = 32'h1122_3344;
        step();
        idle();
        en[0] = 1'b1; addr[0] = 4'd5;
        step();
        flush();
        chk("be_rf", dout_rf[0], 32'hDE22_BE44);
        chk("be_wf", dout_wf[0], 32'hDE22_BE44);

        // Same-port and cross-port read-during-write.
        en = 2'b11; we = 2'b01; be[0] = 4'hF; addr[0] = 4'd2; addr[1] = 4'd2; din[0] = 32'hAAAA_AAAA;
        step();
        flush();
        chk("rdw_rf_a", dout_rf[0], 32'hDEAD_BEEF);
        chk("rdw_wf_a", dout_wf[0], 32'hAAAA_AAAA);
        chk("rdw_rf_b", dout_rf[1], 32'hDEAD_BEEF);
        chk("rdw_wf_b", dout_wf[1], 32'hDEAD_BEEF);

        // Same-address dual write.
        en = 2'b11; we = 2'b11; be[0] = 4'hF; be[1] = 4'h3; addr[0] = 4'd9; addr[1] = 4'd9;
        din[0] = 32'h0000_0000; din[1] = 32'hFFFF_FFFF;
        step();
        chk("coll_pulse", {31'b0, coll_rf}, 32'd1);
        idle();
        en[0] = 1'b1; addr[0] = 4'd9;
        step();
        chk("coll_drop", {31'b0, coll_rf}, 32'd0);
        flush();
        chk("coll_data", dout_rf[0], 32'h0000_FFFF);

        // Back-to-back stream on port B.
        for (int a = 0; a < DEPTH; a++) begin
            idle();
            en[1] = 1'b1; addr[1] = 4'(a);
            step();
        end
        flush();

        // Random traffic with frequent address overlap.
        repeat (300) begin
            en      = 2'($urandom_range(0, 3));
            we      = 2'($urandom_range(0, 3));
            be[0]   = 4'($urandom_range(0, 15));
            be[1]   = 4'($urandom_range(0, 15));
            addr[0] = 4'($urandom_range(0, 15));
            addr[1] = ($urandom_range(0, 3) == 0) ? addr[0] : 4'($urandom_range(0, 15));
            din[0]  = $urandom;
            din[1]  = $urandom;
            step();
        end
        flush();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
